divclk_monitor: RTL and testbench

DIVCLK_MONITOR -- requirements
Module: divclk_monitor

---
 rtl/divclk_monitor_pkg.sv | 18 +
 rtl/divclk_edge.sv | 59 +++++
 rtl/divclk_monitor.sv | 179 +++++++++++++++++
 tb/tb_divclk_monitor.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/divclk_monitor_pkg.sv
// Shared types and default constants for the divided-clock monitor.
package divclk_monitor_pkg;

    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_LOCK_CNT = 4;
    localparam int unsigned DEF_TOL      = 1;

    // Match counter width covers the full LOCK_CNT range of 1..15.
    localparam int unsigned MATCH_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED,
        LOST
    } state_e;

endpackage

// File: rtl/divclk_edge.sv
// Samples div_clk_i into s and generates registered rise/fall pulses.
// Defining DIVCLK_MONITOR_SYNC_EN adds a metastability stage ahead of s.
module divclk_edge
    import divclk_monitor_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic div_clk_i,
    output logic rise_now_o,
    output logic rise_o,
    output logic fall_o
);

    logic samp_d;
    logic samp_q;
    logic samp_prev_q;
    logic fall_now;

`ifdef DIVCLK_MONITOR_SYNC_EN
    // meta_q and samp_q together form the 2-flop synchronizer; samp_q is s.
    logic meta_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
        end else begin
            meta_q <= div_clk_i;
        end
    end

    always_comb begin
        samp_d = meta_q;
    end
`else
    always_comb begin
        samp_d = div_clk_i;
    end
`endif

    always_comb begin
        rise_now_o = samp_q & ~samp_prev_q;
        fall_now   = ~samp_q & samp_prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp_q      <= 1'b0;
            samp_prev_q <= 1'b0;
            rise_o      <= 1'b0;
            fall_o      <= 1'b0;
        end else begin
            samp_q      <= samp_d;
            samp_prev_q <= samp_q;
            rise_o      <= rise_now_o;
            fall_o      <= fall_now;
        end
    end

endmodule

// File: rtl/divclk_monitor.sv
// Measures the rise-to-rise period of div_clk_i and tracks lock/loss of it.
// Optional input synchronizer is enabled by defining DIVCLK_MONITOR_SYNC_EN.
module divclk_monitor
    import divclk_monitor_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
    parameter int unsigned TOL      = DEF_TOL
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             div_clk_i,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic             locked_o,
    output logic             lost_o
);

    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W:0]     TOL_V   = (CNT_W+1)'(TOL);
    localparam logic [MATCH_W-1:0] LOCK_V  = MATCH_W'(LOCK_CNT);

    logic               rise_now;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               pv_q, pv_d;
    logic               armed_q, armed_d;

    state_e             state_q;
    logic [MATCH_W-1:0] match_q;
    logic [MATCH_W-1:0] match_inc;
    logic [CNT_W-1:0]   prev_q;
    logic [CNT_W-1:0]   lock_ref_q;
    logic               ref_valid_q;
    logic               locked_q;
    logic               lost_q;

    logic               sat;
    logic               go_lost;

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        logic [CNT_W:0] ax;
        logic [CNT_W:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        return (ax >= bx) ? (ax - bx) : (bx - ax);
    endfunction

    divclk_edge u_edge (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .div_clk_i  (div_clk_i),
        .rise_now_o (rise_now),
        .rise_o     (rise_o),
        .fall_o     (fall_o)
    );

    // Counter and period capture run on the unregistered rise so that
    // period_valid_o lines up with rise_o; the FSM then acts one cycle later.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        pv_d     = 1'b0;
        armed_d  = armed_q;
        if (rise_now) begin
            cnt_d   = CNT_W'(1);
            armed_d = 1'b1;
            if (armed_q) begin
                period_d = cnt_q;
                pv_d     = 1'b1;
            end
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (go_lost) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        match_inc = match_q + 1'b1;
        sat       = (cnt_q == CNT_MAX) && !rise_now;
        go_lost   = 1'b0;
        if (state_q == MEASURE) begin
            go_lost = sat;
        end else if (state_q == LOCKED) begin
            go_lost = sat || (pv_q && (abs_diff(period_q, lock_ref_q) > TOL_V));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            match_q     <= '0;
            prev_q      <= '0;
            lock_ref_q  <= '0;
            ref_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise_o) begin
                        state_q     <= MEASURE;
                        match_q     <= '0;
                        ref_valid_q <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (go_lost) begin
                        state_q <= LOST;
                        lost_q  <= 1'b1;
                    end else if (pv_q) begin
                        prev_q <= period_q;
                        if (!ref_valid_q) begin
                            ref_valid_q <= 1'b1;
                        end else if (abs_diff(period_q, prev_q) <= TOL_V) begin
                            match_q <= match_inc;
                            if (match_inc >= LOCK_V) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                lock_ref_q <= period_q;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (go_lost) begin
                        state_q  <= LOST;
                        locked_q <= 1'b0;
                        lost_q   <= 1'b1;
                    end
                end
                LOST: begin
                    if (rise_o) begin
                        state_q     <= MEASURE;
                        lost_q      <= 1'b0;
                        match_q     <= '0;
                        ref_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    locked_q <= 1'b0;
                    lost_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        period_o       = period_q;
        period_valid_o = pv_q;
        locked_o       = locked_q;
        lost_o         = lost_q;
    end

endmodule

// File: tb/tb_divclk_monitor.sv
// Directed self-checking bench for divclk_monitor (default parameters).
module tb_divclk_monitor;

`ifdef DIVCLK_MONITOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic       div_clk;
    logic       rise;
    logic       fall;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       lost;

    int npass  = 0;
    int ntotal = 0;

    divclk_monitor #(
        .CNT_W    (8),
        .LOCK_CNT (4),
        .TOL      (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .div_clk_i      (div_clk),
        .rise_o         (rise),
        .fall_o         (fall),
        .period_o       (period),
        .period_valid_o (period_valid),
        .locked_o       (locked),
        .lost_o         (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drives one div_clk period of p cycles (high p/2, then low) and records
    // what the monitor reports for the rise that starts it.
    task automatic one_period(input int p, output int rise_off, output int fall_off,
                              output logic [7:0] per, output logic pv, output logic lost_next);
        rise_off  = -1;
        fall_off  = -1;
        per       = '0;
        pv        = 1'b0;
        lost_next = 1'b0;
        div_clk   = 1'b1;
        for (int i = 1; i <= p; i++) begin
            if (i == p / 2 + 1) div_clk = 1'b0;
            cyc(1);
            if (rise === 1'b1 && rise_off < 0) begin
                rise_off = i;
                per      = period;
                pv       = period_valid;
            end
            if (rise_off >= 0 && i == rise_off + 1) lost_next = lost;
            if (fall === 1'b1 && fall_off < 0) fall_off = i;
        end
    endtask

    initial begin
        int         ro;
        int         fo;
        logic [7:0] pr;
        logic       pv;
        logic       ln;
        int         j;

        rst     = 1'b1;
        div_clk = 1'b0;
        cyc(3);
        chk("reset_outputs", {rise, fall, period_valid, locked, lost, period}, 0);
        rst = 1'b0;
        cyc(2);

        // Edge latency from the sampling edge; this rise leaves IDLE.
        div_clk = 1'b1;
        for (int i = 1; i <= LAT + 1; i++) begin
            cyc(1);
            chk("rise_latency", rise, (i == LAT + 1) ? 1 : 0);
            if (i == LAT + 1) chk("first_rise_no_valid", period_valid, 0);
        end
        cyc(1);
        chk("rise_single_pulse", rise, 0);
        cyc(4 - (LAT + 2));
        div_clk = 1'b0;
        cyc(4);

        // Period 8: reference, then four matches lock.
        one_period(8, ro, fo, pr, pv, ln);
        chk("p8_rise_offset", ro, LAT + 1);
        chk("p8_fall_offset", fo, 4 + LAT + 1);
        chk("p8_ref_valid", pv, 1);
        chk("p8_ref_period", pr, 8);
        for (int k = 0; k < 3; k++) begin
            one_period(8, ro, fo, pr, pv, ln);
            chk("p8_period", pr, 8);
        end
        chk("p8_not_yet_locked", locked, 0);
        one_period(8, ro, fo, pr, pv, ln);
        chk("p8_locked", locked, 1);

        // Periods 9, 7, 8 stay within tolerance.
        one_period(9, ro, fo, pr, pv, ln);
        one_period(7, ro, fo, pr, pv, ln);
        chk("tol_period9", pr, 9);
        chk("tol_locked9", locked, 1);
        one_period(8, ro, fo, pr, pv, ln);
        chk("tol_period7", pr, 7);
        chk("tol_locked7", locked, 1);
        one_period(8, ro, fo, pr, pv, ln);
        chk("tol_period8", pr, 8);
        chk("tol_locked8", locked, 1);

        // A period of 10 loses lock one cycle after its rise.
        one_period(10, ro, fo, pr, pv, ln);
        one_period(8, ro, fo, pr, pv, ln);
        chk("p10_period", pr, 10);
        chk("p10_lost_next_cycle", ln, 1);
        chk("p10_locked_low", locked, 0);

        // Rise in LOST returns to MEASURE without a period update.
        one_period(8, ro, fo, pr, pv, ln);
        chk("lost_rise_seen", ro, LAT + 1);
        chk("lost_rise_no_valid", pv, 0);
        chk("lost_rise_period_held", pr, 10);
        chk("lost_exit", lost, 0);

        // Counter saturation with div_clk held low.
        j = 0;
        while (lost !== 1'b1 && j < 400) begin
            cyc(1);
            j++;
        end
        chk("sat_lost_cycles", j, 248 + LAT);
        one_period(8, ro, fo, pr, pv, ln);
        chk("sat_rise_no_valid", pv, 0);
        chk("sat_exit_lost", lost, 0);

        for (int k = 0; k < 5; k++) one_period(8, ro, fo, pr, pv, ln);
        chk("relock_before_reset", locked, 1);

        // Reset pulse while locked, div_clk high across release.
        div_clk = 1'b1;
        rst     = 1'b1;
        cyc(1);
        chk("midreset_outputs", {rise, fall, period_valid, locked, lost, period}, 0);
        rst = 1'b0;
        cyc(1);
        chk("post_release_no_edge", {rise, fall}, 0);
        cyc(3);
        div_clk = 1'b0;
        cyc(4);
        for (int k = 0; k < 4; k++) one_period(8, ro, fo, pr, pv, ln);
        chk("reset_relock_pending", locked, 0);
        one_period(8, ro, fo, pr, pv, ln);
        chk("reset_relocked", locked, 1);
        chk("reset_relock_period", pr, 8);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
